// File: rtl/srm_pkg.sv
// srm_pkg: shared opcode, shift and state encodings for the execute sequencer
package srm_pkg;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_NOT} alu_op_e;
  typedef enum logic [1:0] {SH_NONE, SH_LSL, SH_LSR, SH_ASR} shift_e;
  typedef enum logic [2:0] {IDLE, RDA, RDB, EXEC, WB} state_e;
endpackage

// File: rtl/shift_alu.sv
// shift_alu: combinational operand-B shifter feeding a 4-function ALU with Z/N/V flags
module shift_alu import srm_pkg::*; #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        alu_op,
  input  logic [1:0]        shift,
  output logic [DATA_W-1:0] c,
  output logic              z,
  output logic              n,
  output logic              v
);
  localparam int M = DATA_W - 1;
  logic [DATA_W-1:0] bsh, sum, dif;
  // shift B, evaluate every ALU function, pick one and derive the flags
  always_comb begin
    bsh = shift == SH_LSL ? {b[M-1:0], 1'b0} :
          shift == SH_LSR ? {1'b0, b[M:1]} :
          shift == SH_ASR ? {b[M], b[M:1]} : b;
    sum = a + bsh;
    dif = a - bsh;
    c = alu_op == ALU_ADD ? sum :
        alu_op == ALU_SUB ? dif :
        alu_op == ALU_AND ? a & bsh : ~bsh;
    v = alu_op == ALU_ADD ? (a[M] == bsh[M]) && (sum[M] != a[M]) :
        alu_op == ALU_SUB ? (a[M] != bsh[M]) && (dif[M] != a[M]) : 1'b0;
    z = c == '0;
    n = c[M];
  end
endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle read/read/execute/writeback sequencer driving an 8x16 regfile
module exec_sequencer import srm_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        alu_op,
  input  logic [1:0]        shift,
  input  logic [REG_AW-1:0] rn,
  input  logic [REG_AW-1:0] rm,
  input  logic [REG_AW-1:0] rd,
  input  logic              wb_en,
  input  logic              s_en,
  input  logic [DATA_W-1:0] rf_data_out,
  output logic [REG_AW-1:0] rf_readnum,
  output logic [REG_AW-1:0] rf_writenum,
  output logic              rf_write,
  output logic [DATA_W-1:0] rf_data_in,
  output logic [DATA_W-1:0] result,
  output logic [2:0]        status,
  output logic              busy,
  output logic              done
);
  state_e state, nxt;
  logic [DATA_W-1:0] a, b, c, alu_c;
  logic [1:0] alu_op_q, shift_q;
  logic [REG_AW-1:0] rm_q, rd_q;
  logic wb_en_q, s_en_q, accept, z, n, v;
  assign accept = start && (state == IDLE || state == WB);
  // next state: a start accepted in WB chains straight into the next RDA
  always_comb begin
    nxt = accept ? RDA :
          state == RDA ? RDB :
          state == RDB ? EXEC :
          state == EXEC ? WB : IDLE;
  end
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= nxt;
  end
  // operand capture, field latching, result and status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a <= '0;
      b <= '0;
      c <= '0;
      status <= '0;
      rf_readnum <= '0;
      alu_op_q <= '0;
      shift_q <= '0;
      rm_q <= '0;
      rd_q <= '0;
      wb_en_q <= 1'b0;
      s_en_q <= 1'b0;
    end else begin
      if (accept) begin
        alu_op_q <= alu_op;
        shift_q <= shift;
        rm_q <= rm;
        rd_q <= rd;
        wb_en_q <= wb_en;
        s_en_q <= s_en;
        rf_readnum <= rn;
      end
      if (state == RDA) begin
        a <= rf_data_out;
        rf_readnum <= rm_q;
      end
      if (state == RDB) b <= rf_data_out;
      if (state == EXEC) begin
        c <= alu_c;
        if (s_en_q) status <= {z, n, v};
      end
    end
  end
  shift_alu #(.DATA_W(DATA_W)) u_alu (
    .a(a), .b(b), .alu_op(alu_op_q), .shift(shift_q),
    .c(alu_c), .z(z), .n(n), .v(v)
  );
  assign rf_write = state == WB && wb_en_q;
  assign rf_writenum = rd_q;
  assign rf_data_in = c;
  assign result = c;
  assign busy = state != IDLE;
  assign done = state == WB;
endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: scoreboard bench for exec_sequencer against a behavioural 8x16 regfile
module tb_exec_sequencer;
  import srm_pkg::*;
  typedef struct {logic [15:0] c; logic [2:0] st;} exp_t;
  logic clk = 0, reset = 1, start = 0, wb_en = 0, s_en = 0;
  logic [1:0] alu_op = 0, shift = 0;
  logic [2:0] rn = 0, rm = 0, rd = 0;
  logic [15:0] rf_data_out, rf_data_in, result;
  logic [2:0] rf_readnum, rf_writenum, status;
  logic rf_write, busy, done;
  logic [15:0] rf [8];
  logic [15:0] mdl [8];
  logic [2:0] mdl_st = 0;
  logic pl_en = 0;
  logic [2:0] pl_addr = 0;
  logic [15:0] pl_data = 0;
  exp_t sb[$];
  int checks = 0, failures = 0, done_cnt = 0, wr_cnt = 0;

  exec_sequencer #(.DATA_W(16), .REG_AW(3)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_op(alu_op), .shift(shift),
    .rn(rn), .rm(rm), .rd(rd), .wb_en(wb_en), .s_en(s_en),
    .rf_data_out(rf_data_out), .rf_readnum(rf_readnum), .rf_writenum(rf_writenum),
    .rf_write(rf_write), .rf_data_in(rf_data_in), .result(result),
    .status(status), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  assign rf_data_out = rf[rf_readnum];
  always @(posedge clk) begin
    if (pl_en) rf[pl_addr] <= pl_data;
    else if (rf_write) rf[rf_writenum] <= rf_data_in;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic [1:0] op, input logic [1:0] sh);
    logic [15:0] ys, r;
    logic signed [15:0] ysg;
    int s;
    logic ov;
    ysg = y;
    ysg = ysg >>> 1;
    if (sh == 2'd1) ys = y << 1;
    else if (sh == 2'd2) ys = y >> 1;
    else if (sh == 2'd3) ys = ysg;
    else ys = y;
    s = 0;
    if (op == 2'd0) s = int'($signed(x)) + int'($signed(ys));
    if (op == 2'd1) s = int'($signed(x)) - int'($signed(ys));
    r = op < 2 ? s[15:0] : op == 2'd2 ? (x & ys) : ~ys;
    ov = (op < 2) && (s > 32767 || s < -32768);
    return {r, r == 16'h0, r[15], ov};
  endfunction

  task automatic poke(input logic [2:0] ad, input logic [15:0] d);
    pl_en = 1; pl_addr = ad; pl_data = d; mdl[ad] = d;
    @(posedge clk); #1 pl_en = 0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] sh, input logic [2:0] n,
                       input logic [2:0] m, input logic [2:0] d, input logic wb, input logic se);
    logic [18:0] r;
    alu_op = op; shift = sh; rn = n; rm = m; rd = d; wb_en = wb; s_en = se; start = 1;
    r = model(mdl[n], mdl[m], op, sh);
    if (se) mdl_st = r[2:0];
    sb.push_back('{r[18:3], mdl_st});
    if (wb) mdl[d] = r[18:3];
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 20);
    check("done_seen", done, 1);
  endtask

  always @(negedge clk) begin
    if (rf_write) wr_cnt++;
    if (done) begin
      done_cnt++;
      check("sb_depth", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.c);
        check("status", status, e.st);
        check("data_in", rf_data_in, e.c);
      end
    end
  end

  initial begin
    int lat, w0, d0;
    logic [15:0] old;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_write", rf_write, 0);
    check("rst_result", result, 0);
    check("rst_status", status, 0);
    reset = 0;
    for (int i = 0; i < 8; i++) poke(3'(i), i == 1 ? 16'h0005 : i == 2 ? 16'h0003 : 16'h0000);
    // 1: ADD R3 = R1 + R2
    issue(ALU_ADD, SH_NONE, 1, 2, 3, 1, 1);
    check("t1_busy", busy, 1);
    wait_done(lat);
    check("t1_latency", lat, 4);
    check("t1_wr", rf_write, 1);
    @(negedge clk);
    check("t1_r3", rf[3], 16'h0008);
    check("t1_idle", busy, 0);
    // 2: SUB R1 - R1, no writeback
    w0 = wr_cnt;
    issue(ALU_SUB, SH_NONE, 1, 1, 0, 0, 1);
    wait_done(lat);
    @(negedge clk);
    check("t2_writes", wr_cnt - w0, 0);
    check("t2_status", status, 3'b100);
    for (int i = 0; i < 8; i++) check($sformatf("t2_r%0d", i), rf[i], mdl[i]);
    // 3: overflow on ADD, then NOT of arithmetic-shifted operand
    poke(1, 16'h7FFF);
    issue(ALU_ADD, SH_NONE, 1, 1, 4, 1, 1);
    wait_done(lat);
    @(negedge clk);
    check("t3_r4", rf[4], 16'hFFFE);
    check("t3_status", status, 3'b011);
    poke(2, 16'h8000);
    issue(ALU_NOT, SH_ASR, 0, 2, 5, 1, 0);
    wait_done(lat);
    @(negedge clk);
    check("t3_r5", rf[5], 16'h3FFF);
    // 4: back-to-back with RAW dependency on R6
    issue(ALU_ADD, SH_NONE, 1, 2, 6, 1, 0);
    wait_done(lat);
    issue(ALU_ADD, SH_NONE, 6, 6, 7, 1, 0);
    check("t4_no_idle", busy, 1);
    wait_done(lat);
    check("t4_latency", lat, 4);
    @(negedge clk);
    check("t4_r6", rf[6], 16'hFFFF);
    check("t4_r7", rf[7], 16'hFFFE);
    // 5: start while busy is dropped
    d0 = done_cnt;
    issue(ALU_AND, SH_NONE, 1, 2, 3, 1, 1);
    alu_op = ALU_SUB; rn = 2; rm = 1; rd = 0; wb_en = 1; s_en = 0; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (8) @(negedge clk);
    check("t5_dones", done_cnt - d0, 1);
    check("t5_r3", rf[3], 16'h0000);
    check("t5_r0", rf[0], mdl[0]);
    check("t5_status", status, 3'b100);
    // 6: reset during WB aborts the write
    old = mdl[2];
    issue(ALU_ADD, SH_LSL, 1, 1, 2, 1, 1);
    wait_done(lat);
    #1;
    check("t6_wr_before", rf_write, 1);
    reset = 1;
    #1;
    check("t6_wr", rf_write, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_result", result, 0);
    check("t6_status", status, 0);
    mdl[2] = old;
    mdl_st = 0;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    check("t6_r2", rf[2], 16'h8000);
    issue(ALU_SUB, SH_NONE, 1, 2, 3, 1, 1);
    wait_done(lat);
    check("t6_latency", lat, 4);
    @(negedge clk);
    check("t6_r3", rf[3], 16'hFFFF);
    check("t6_status2", status, 3'b011);
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
